satd_residual_block: RTL and testbench



---
 rtl/satd_pkg.sv | 25 ++
 rtl/satd_diff_row.sv | 42 ++++
 rtl/satd_residual_block.sv | 137 +++++++++++++
 tb/tb_satd_residual_block.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/satd_pkg.sv
// Shared constants, width helpers and bank state type for the SATD residual stage.
package satd_pkg;

  localparam int BIT_DEPTH_DEF = 8;
  localparam int N_DEF         = 8;

  typedef enum logic [1:0] {
    EMPTY,
    FILLING,
    FULL
  } bank_state_e;

  function automatic int diff_w(input int bd);
    return bd + 1;
  endfunction

  function automatic int row_sad_w(input int bd, input int n);
    return bd + $clog2(n);
  endfunction

  function automatic int sad_w(input int bd, input int n);
    return bd + 2 * $clog2(n);
  endfunction

endpackage

// File: rtl/satd_diff_row.sv
// Combinational N-lane signed subtractor; with SATD_RESID_SAD_EN also sums |diff| over the row.
module satd_diff_row
  import satd_pkg::*;
#(
  parameter  int BIT_DEPTH = BIT_DEPTH_DEF,
  parameter  int N         = N_DEF,
  localparam int DW        = diff_w(BIT_DEPTH)
) (
  input  logic [N*BIT_DEPTH-1:0] org_row,
  input  logic [N*BIT_DEPTH-1:0] cur_row,
  output logic [N*DW-1:0]        diff_row
`ifdef SATD_RESID_SAD_EN
  ,
  output logic [row_sad_w(BIT_DEPTH, N)-1:0] row_sad
`endif
);

`ifdef SATD_RESID_SAD_EN
  localparam int RSW = row_sad_w(BIT_DEPTH, N);
  logic [DW-1:0] mag;
`endif
  logic [DW-1:0] d;

  always_comb begin
    diff_row = '0;
    d        = '0;
`ifdef SATD_RESID_SAD_EN
    row_sad  = '0;
    mag      = '0;
`endif
    for (int unsigned c = 0; c < N; c++) begin
      // zero-extended subtraction: the extra bit makes the result exact and signed
      d = {1'b0, org_row[c*BIT_DEPTH +: BIT_DEPTH]} - {1'b0, cur_row[c*BIT_DEPTH +: BIT_DEPTH]};
      diff_row[c*DW +: DW] = d;
`ifdef SATD_RESID_SAD_EN
      mag     = d[DW-1] ? DW'(-d) : d;
      row_sad = row_sad + RSW'(mag);
`endif
    end
  end

endmodule

// File: rtl/satd_residual_block.sv
// Ping-pong NxN residual block assembler feeding the SATD transform.
// Optional SATD_RESID_SAD_EN adds out_sad (sum of |diff| per delivered block).
module satd_residual_block
  import satd_pkg::*;
#(
  parameter  int BIT_DEPTH = BIT_DEPTH_DEF,
  parameter  int N         = N_DEF,
  localparam int DW        = diff_w(BIT_DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N*BIT_DEPTH-1:0] org_row,
  input  logic [N*BIT_DEPTH-1:0] cur_row,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [N*N*DW-1:0]      out_blk
`ifdef SATD_RESID_SAD_EN
  ,
  output logic [sad_w(BIT_DEPTH, N)-1:0] out_sad
`endif
);

  localparam int RW = $clog2(N);

  bank_state_e    bank_st   [2];
  bank_state_e    bank_st_n [2];
  logic           wr_bank, wr_bank_n;
  logic           rd_bank, rd_bank_n;
  logic [RW-1:0]  wr_row, wr_row_n;
  logic [N*DW-1:0] mem [2][N];
  logic [N*DW-1:0] diff_row;
  logic           accept, drain, flush_fill;

`ifdef SATD_RESID_SAD_EN
  localparam int SW  = sad_w(BIT_DEPTH, N);
  localparam int RSW = row_sad_w(BIT_DEPTH, N);
  logic [RSW-1:0] row_sad;
  logic [SW-1:0]  sad_acc [2];
`endif

  satd_diff_row #(
    .BIT_DEPTH(BIT_DEPTH),
    .N        (N)
  ) u_diff (
    .org_row (org_row),
    .cur_row (cur_row),
    .diff_row(diff_row)
`ifdef SATD_RESID_SAD_EN
    ,
    .row_sad (row_sad)
`endif
  );

  assign accept     = in_valid && in_ready;
  assign drain      = out_valid && out_ready;
  assign flush_fill = flush && (bank_st[wr_bank] == FILLING);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned b = 0; b < 2; b++) bank_st[b] <= EMPTY;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      wr_row    <= '0;
      out_valid <= 1'b0;
    end else begin
      bank_st   <= bank_st_n;
      wr_bank   <= wr_bank_n;
      rd_bank   <= rd_bank_n;
      wr_row    <= wr_row_n;
      out_valid <= (bank_st_n[rd_bank_n] == FULL);
    end
  end

  // Drain and fill always target different banks, so both updates can apply together.
  always_comb begin
    bank_st_n = bank_st;
    wr_bank_n = wr_bank;
    rd_bank_n = rd_bank;
    wr_row_n  = wr_row;
    if (drain) begin
      bank_st_n[rd_bank] = EMPTY;
      rd_bank_n          = ~rd_bank;
    end
    if (flush_fill) begin
      bank_st_n[wr_bank] = EMPTY;
      wr_row_n           = '0;
    end else if (accept) begin
      if (wr_row == RW'(N-1)) begin
        bank_st_n[wr_bank] = FULL;
        wr_row_n           = '0;
        wr_bank_n          = ~wr_bank;
      end else begin
        bank_st_n[wr_bank] = FILLING;
        wr_row_n           = wr_row + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned b = 0; b < 2; b++)
        for (int unsigned r = 0; r < N; r++)
          mem[b][r] <= '0;
    end else if (accept) begin
      mem[wr_bank][wr_row] <= diff_row;
    end
  end

`ifdef SATD_RESID_SAD_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sad_acc[0] <= '0;
      sad_acc[1] <= '0;
    end else begin
      if (drain) sad_acc[rd_bank] <= '0;
      if (flush_fill) sad_acc[wr_bank] <= '0;
      else if (accept)
        sad_acc[wr_bank] <= ((wr_row == '0) ? '0 : sad_acc[wr_bank]) + SW'(row_sad);
    end
  end
`endif

  always_comb begin
    in_ready = !rst && !flush && (bank_st[wr_bank] != FULL);
    out_blk  = '0;
    if (out_valid)
      for (int unsigned r = 0; r < N; r++)
        out_blk[r*N*DW +: N*DW] = mem[rd_bank][r];
`ifdef SATD_RESID_SAD_EN
    out_sad = out_valid ? sad_acc[rd_bank] : '0;
`endif
  end

endmodule

// File: tb/tb_satd_residual_block.sv
// Self-checking bench for satd_residual_block: directed steps plus random traffic vs a block-FIFO model.
module tb_satd_residual_block;

  localparam int BD = 8;
  localparam int N  = 8;
  localparam int DW = BD + 1;
  localparam int NE = N * N;
  localparam int BW = NE * DW;
  localparam int RB = N * BD;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic          in_ready, out_valid;
  logic [RB-1:0] org_row = '0;
  logic [RB-1:0] cur_row = '0;
  logic [BW-1:0] out_blk;
`ifdef SATD_RESID_SAD_EN
  logic [BD+2*$clog2(N)-1:0] out_sad;
`endif

  satd_residual_block #(.BIT_DEPTH(BD), .N(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .org_row  (org_row),
    .cur_row  (cur_row),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_blk  (out_blk)
`ifdef SATD_RESID_SAD_EN
    ,
    .out_sad  (out_sad)
`endif
  );

  always #5 clk = ~clk;

  // Model: completed blocks wait in a two-deep FIFO; the partial block is a row list.
  typedef int blk_t [NE];
  blk_t full_q [$];
  blk_t part;
  int   pcnt = 0;
  int   n_asrt = 0;
  int   n_fail = 0;

  task automatic chk(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    n_asrt++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [BW-1:0] pack(input blk_t b);
    logic [BW-1:0] v;
    v = '0;
    for (int i = 0; i < NE; i++) v[i*DW +: DW] = DW'(b[i]);
    return v;
  endfunction

  function automatic int abs_sum(input blk_t b);
    int s;
    s = 0;
    for (int i = 0; i < NE; i++) s += (b[i] < 0) ? -b[i] : b[i];
    return s;
  endfunction

  function automatic logic [RB-1:0] rep(input logic [BD-1:0] v);
    logic [RB-1:0] r;
    for (int i = 0; i < N; i++) r[i*BD +: BD] = v;
    return r;
  endfunction

  function automatic logic [RB-1:0] rnd_row();
    logic [RB-1:0] r;
    for (int i = 0; i < N; i++) r[i*BD +: BD] = BD'($urandom);
    return r;
  endfunction

  task automatic cycle(input bit v, input logic [RB-1:0] ov, input logic [RB-1:0] cv,
                       input bit fl, input bit ordy);
    bit er, ev, acc, drn;
    @(negedge clk);
    in_valid  = v;
    org_row   = ov;
    cur_row   = cv;
    flush     = fl;
    out_ready = ordy;
    #1;
    er = !fl && (full_q.size() < 2);
    ev = (full_q.size() > 0);
    chk("in_ready", BW'(in_ready), BW'(er));
    chk("out_valid", BW'(out_valid), BW'(ev));
    chk("out_blk", out_blk, ev ? pack(full_q[0]) : '0);
`ifdef SATD_RESID_SAD_EN
    chk("out_sad", BW'(out_sad), ev ? BW'(abs_sum(full_q[0])) : '0);
`endif
    acc = v && er;
    drn = ev && ordy;
    @(posedge clk);
    if (drn) void'(full_q.pop_front());
    if (fl) pcnt = 0;
    else if (acc) begin
      for (int c = 0; c < N; c++)
        part[pcnt*N + c] = int'(ov[c*BD +: BD]) - int'(cv[c*BD +: BD]);
      pcnt++;
      if (pcnt == N) begin
        full_q.push_back(part);
        pcnt = 0;
      end
    end
  endtask

  initial begin
    logic [RB-1:0] r17o, r17c;

    // reset state
    #12;
    chk("rst_in_ready", BW'(in_ready), '0);
    chk("rst_out_valid", BW'(out_valid), '0);
    chk("rst_out_blk", out_blk, '0);
    @(negedge clk);
    rst = 1'b0;

    // +255 everywhere
    for (int i = 0; i < N; i++) cycle(1, rep(8'hFF), rep(8'h00), 0, 0);
    cycle(0, '0, '0, 0, 0);
    #1;
    chk("pos255_first", BW'(out_blk[DW-1:0]), BW'(9'h0FF));
    chk("pos255_last", BW'(out_blk[BW-1 -: DW]), BW'(9'h0FF));
    cycle(0, '0, '0, 0, 1);

    // -255 everywhere
    for (int i = 0; i < N; i++) cycle(1, rep(8'h00), rep(8'hFF), 0, 0);
    cycle(0, '0, '0, 0, 0);
    #1;
    chk("neg255_first", BW'(out_blk[DW-1:0]), BW'(9'h101));
    cycle(0, '0, '0, 0, 1);

    // equal samples give zero
    for (int i = 0; i < N; i++) cycle(1, rep(8'h80), rep(8'h80), 0, 0);
    cycle(0, '0, '0, 0, 1);

    // both banks full, then back-to-back drain; 17th row lands in the freed bank
    for (int i = 0; i < 2*N; i++) cycle(1, rnd_row(), rnd_row(), 0, 0);
    r17o = rnd_row();
    r17c = rnd_row();
    cycle(1, r17o, r17c, 0, 0);
    cycle(1, r17o, r17c, 0, 1);
    cycle(1, r17o, r17c, 0, 1);
    for (int i = 1; i < N; i++) cycle(1, rnd_row(), rnd_row(), 0, 0);
    cycle(0, '0, '0, 0, 1);

    // partial block discarded by flush (row offered during flush is dropped)
    for (int i = 0; i < 3; i++) cycle(1, rep(8'h10), rep(8'h00), 0, 0);
    cycle(1, rep(8'h10), rep(8'h00), 1, 0);
    for (int i = 0; i < N; i++) cycle(1, rep(8'h15), rep(8'h10), 0, 0);
    cycle(0, '0, '0, 0, 0);
    #1;
    chk("flush_plus5", BW'(out_blk[DW-1:0]), BW'(9'h005));
    cycle(0, '0, '0, 0, 1);

    // asynchronous reset mid-block with one bank full
    for (int i = 0; i < N + 3; i++) cycle(1, rnd_row(), rnd_row(), 0, 0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", BW'(out_valid), '0);
    chk("arst_in_ready", BW'(in_ready), '0);
    chk("arst_out_blk", out_blk, '0);
    full_q.delete();
    pcnt = 0;
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < N; i++) cycle(1, rnd_row(), rnd_row(), 0, 0);
    cycle(0, '0, '0, 0, 1);

    // random traffic
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 3) != 0, rnd_row(), rnd_row(),
            $urandom_range(0, 19) == 0, $urandom_range(0, 2) != 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
